// File: rtl/term_inj_arbiter.sv
// Round-robin arbiter feeding one mesh-router terminal injection port from NREQ pending/pop FIFO heads.
// Optional offer watchdog built when TERM_INJ_ARB_TIMEOUT_EN is defined; otherwise timeout_err is tied low.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | nothing held; arbitrate among req_pndng, pop the winner
// S_OFFER | hold_q offered on pndng_i_in until popin is sampled high
module term_inj_arbiter #(
    parameter int NREQ    = 4,
    parameter int pckg_sz = 40,
    parameter int TIMEOUT = 50
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_pndng,
    input  logic [NREQ*pckg_sz-1:0]   req_data,
    output logic [NREQ-1:0]           req_pop,
    output logic                      pndng_i_in,
    output logic [pckg_sz-1:0]        data_out_i_in,
    input  logic                      popin,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      timeout_err
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_grant;
    logic [NREQ-1:0]    r_pop;
    logic [pckg_sz-1:0] r_hold;
    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [pckg_sz-1:0] w_win_data;

    // Lower-priority pass (below ptr) first; the at-or-above-ptr pass overrides it.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_data = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_pndng[i] && (i < int'(r_ptr))) begin
                w_found    = 1'b1;
                w_win      = IDW'(i);
                w_win_data = req_data[i*pckg_sz +: pckg_sz];
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_pndng[i] && (i >= int'(r_ptr))) begin
                w_found    = 1'b1;
                w_win      = IDW'(i);
                w_win_data = req_data[i*pckg_sz +: pckg_sz];
            end
        end
    end

    assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_OFFER;
            S_OFFER: if (popin)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding register and grant only load in IDLE, so they stay frozen for the whole offer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_pop   <= '0;
            r_hold  <= '0;
        end else begin
            r_pop <= '0;
            if (r_state == S_IDLE && w_found) begin
                r_hold  <= w_win_data;
                r_grant <= w_win;
                r_ptr   <= w_ptr_nxt;
                r_pop   <= NREQ'(1) << w_win;
            end
        end
    end

    assign req_pop       = r_pop;
    assign pndng_i_in    = (r_state == S_OFFER);
    assign data_out_i_in = r_hold;
    assign grant_id      = r_grant;

`ifdef TERM_INJ_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Counter saturates at TIMEOUT; the flag is sticky until reset and never disturbs the offer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (!popin) begin
            if (r_cnt == CW'(TIMEOUT - 1)) r_err <= 1'b1;
            if (r_cnt != CW'(TIMEOUT))     r_cnt <= r_cnt + CW'(1);
        end
    end

    assign timeout_err = r_err;
`else
    // Tied low; TIMEOUT only matters when the watchdog is built.
    assign timeout_err = (TIMEOUT < 0);
`endif

endmodule
